// File: rtl/alu_pipe_pkg.sv
// alu_pipe shared types: Y86 op codes, CC reset values, S1 payload.
// ALU_PIPE_CF_EN adds the carry flag to the condition codes.
package alu_pipe_pkg;

    localparam int MAXW  = 64;
    localparam int OPW_P = 4;

    localparam logic [OPW_P-1:0] OP_ADD = 4'd0;
    localparam logic [OPW_P-1:0] OP_SUB = 4'd1;
    localparam logic [OPW_P-1:0] OP_AND = 4'd2;
    localparam logic [OPW_P-1:0] OP_XOR = 4'd3;

    localparam logic CC_ZF_RST = 1'b1;
    localparam logic CC_SF_RST = 1'b0;
    localparam logic CC_OF_RST = 1'b0;
    localparam logic CC_CF_RST = 1'b0;

    typedef struct packed {
        logic [MAXW-1:0]  a;
        logic [MAXW-1:0]  b;
        logic [OPW_P-1:0] op;
        logic             set_cc;
    } s1_t;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe operand/result handshake bundle plus condition codes.
// ALU_PIPE_CF_EN adds cc_cf.
interface alu_pipe_if #(
    parameter int W   = 64,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [OPW-1:0] in_op;
    logic           in_set_cc;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_err;
    logic           cc_zf;
    logic           cc_sf;
    logic           cc_of;
`ifdef ALU_PIPE_CF_EN
    logic           cc_cf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
`ifdef ALU_PIPE_CF_EN
        input  cc_cf,
`endif
        input  in_ready, out_valid, out_result, out_err,
        input  cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
`ifdef ALU_PIPE_CF_EN
        output cc_cf,
`endif
        output in_ready, out_valid, out_result, out_err,
        output cc_zf, cc_sf, cc_of
    );

endinterface

// File: rtl/alu_pipe_core.sv
// Combinational W-bit Y86 ALU: result and ZF/SF/OF (CF with ALU_PIPE_CF_EN).
// Invalid op codes yield a zero result with err set.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [OPW_P-1:0] op_i,
    output logic [W-1:0]     r_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o,
`ifdef ALU_PIPE_CF_EN
    output logic             cf_o,
`endif
    output logic             err_o
);

`ifdef ALU_PIPE_CF_EN
    logic [W:0] sum_w;
    logic [W:0] dif_w;

    assign sum_w = {1'b0, b_i} + {1'b0, a_i};
    assign dif_w = {1'b0, b_i} - {1'b0, a_i};
`endif

    // Op decode, result and flags; Y86 order is b op a.
    always_comb begin
        r_o   = '0;
        of_o  = 1'b0;
        err_o = 1'b0;
`ifdef ALU_PIPE_CF_EN
        cf_o  = 1'b0;
`endif
        unique case (op_i)
            OP_ADD: begin
`ifdef ALU_PIPE_CF_EN
                r_o  = sum_w[W-1:0];
                cf_o = sum_w[W];
`else
                r_o  = b_i + a_i;
`endif
                of_o = (a_i[W-1] == b_i[W-1]) && (r_o[W-1] != b_i[W-1]);
            end
            OP_SUB: begin
`ifdef ALU_PIPE_CF_EN
                r_o  = dif_w[W-1:0];
                cf_o = dif_w[W];
`else
                r_o  = b_i - a_i;
`endif
                of_o = (a_i[W-1] != b_i[W-1]) && (r_o[W-1] != b_i[W-1]);
            end
            OP_AND:  r_o = b_i & a_i;
            OP_XOR:  r_o = b_i ^ a_i;
            default: err_o = 1'b1;
        endcase
        zf_o = (r_o == '0);
        sf_o = r_o[W-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined Y86 ALU with valid/ready backpressure and CC register.
// ALU_PIPE_CF_EN adds the carry flag cc_cf.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int W   = 64,
    parameter int OPW = 4
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);

    logic           s2_adv;
    logic           s1_adv;
    logic           in_fire;
    logic           out_fire;
    logic [OPW-1:0] op_in;

    logic           s1_valid_q, s1_valid_d;
    s1_t            s1_pl_q, s1_pl_d;

    logic           s2_valid_q, s2_valid_d;
    logic [W-1:0]   res_q, res_d;
    logic           err_q, err_d;
    logic           s2_zf_q, s2_zf_d;
    logic           s2_sf_q, s2_sf_d;
    logic           s2_of_q, s2_of_d;
    logic           s2_cc_q, s2_cc_d;

    logic           cc_zf_q, cc_zf_d;
    logic           cc_sf_q, cc_sf_d;
    logic           cc_of_q, cc_of_d;

    logic [W-1:0]   core_r;
    logic           core_zf;
    logic           core_sf;
    logic           core_of;
    logic           core_err;

`ifdef ALU_PIPE_CF_EN
    logic           core_cf;
    logic           s2_cf_q, s2_cf_d;
    logic           cc_cf_q, cc_cf_d;
`endif

    assign s2_adv   = !s2_valid_q || bus.out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_fire  = bus.in_valid && s1_adv;
    assign out_fire = s2_valid_q && bus.out_ready;
    assign op_in    = bus.in_op;

    alu_pipe_core #(.W(W)) u_core (
        .a_i   (s1_pl_q.a[W-1:0]),
        .b_i   (s1_pl_q.b[W-1:0]),
        .op_i  (s1_pl_q.op),
        .r_o   (core_r),
        .zf_o  (core_zf),
        .sf_o  (core_sf),
        .of_o  (core_of),
`ifdef ALU_PIPE_CF_EN
        .cf_o  (core_cf),
`endif
        .err_o (core_err)
    );

    // Next state: stage advance, S2 capture and CC retire on output transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pl_d    = s1_pl_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        err_d      = err_q;
        s2_zf_d    = s2_zf_q;
        s2_sf_d    = s2_sf_q;
        s2_of_d    = s2_of_q;
        s2_cc_d    = s2_cc_q;
        cc_zf_d    = cc_zf_q;
        cc_sf_d    = cc_sf_q;
        cc_of_d    = cc_of_q;
`ifdef ALU_PIPE_CF_EN
        s2_cf_d    = s2_cf_q;
        cc_cf_d    = cc_cf_q;
`endif
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_pl_d.a      = MAXW'(bus.in_a);
            s1_pl_d.b      = MAXW'(bus.in_b);
            s1_pl_d.op     = OPW_P'(op_in);
            s1_pl_d.set_cc = bus.in_set_cc;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d   = core_r;
                err_d   = core_err;
                s2_zf_d = core_zf;
                s2_sf_d = core_sf;
                s2_of_d = core_of;
                s2_cc_d = s1_pl_q.set_cc;
`ifdef ALU_PIPE_CF_EN
                s2_cf_d = core_cf;
`endif
            end
        end
        if (out_fire && s2_cc_q && !err_q) begin
            cc_zf_d = s2_zf_q;
            cc_sf_d = s2_sf_q;
            cc_of_d = s2_of_q;
`ifdef ALU_PIPE_CF_EN
            cc_cf_d = s2_cf_q;
`endif
        end
    end

    // Pipeline and CC registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pl_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
            s2_zf_q    <= 1'b0;
            s2_sf_q    <= 1'b0;
            s2_of_q    <= 1'b0;
            s2_cc_q    <= 1'b0;
            cc_zf_q    <= CC_ZF_RST;
            cc_sf_q    <= CC_SF_RST;
            cc_of_q    <= CC_OF_RST;
`ifdef ALU_PIPE_CF_EN
            s2_cf_q    <= 1'b0;
            cc_cf_q    <= CC_CF_RST;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pl_q    <= s1_pl_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            err_q      <= err_d;
            s2_zf_q    <= s2_zf_d;
            s2_sf_q    <= s2_sf_d;
            s2_of_q    <= s2_of_d;
            s2_cc_q    <= s2_cc_d;
            cc_zf_q    <= cc_zf_d;
            cc_sf_q    <= cc_sf_d;
            cc_of_q    <= cc_of_d;
`ifdef ALU_PIPE_CF_EN
            s2_cf_q    <= s2_cf_d;
            cc_cf_q    <= cc_cf_d;
`endif
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_err    = err_q;
    assign bus.cc_zf      = cc_zf_q;
    assign bus.cc_sf      = cc_sf_q;
    assign bus.cc_of      = cc_of_q;
`ifdef ALU_PIPE_CF_EN
    assign bus.cc_cf      = cc_cf_q;
`endif

endmodule
